regfile_mp: RTL

//  Parametrised multi-port register file for the MIPS core. Provides NUM_RD

---
 rtl/regfile_mp.sv | 111 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports (A, B),
// optional write-to-read bypass, and a per-register busy scoreboard for long-latency ops.
module regfile_mp #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned DEBUG_REG = 2
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_busy_o,
    input  logic                       wa_en_i,
    input  logic [ADDR_W-1:0]          wa_addr_i,
    input  logic [DATA_W-1:0]          wa_data_i,
    input  logic                       wb_en_i,
    input  logic [ADDR_W-1:0]          wb_addr_i,
    input  logic [DATA_W-1:0]          wb_data_i,
    input  logic                       claim_en_i,
    input  logic [ADDR_W-1:0]          claim_addr_i,
    output logic [DATA_W-1:0]          dbg_data_o,
    output logic                       busy_any_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam bit          ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_busy_any;

    logic              w_wa_ok;
    logic              w_wb_ok;
    logic              w_claim_ok;
    logic [DEPTH-1:0]  w_busy_next;

    // Writes and claims aimed at a hardwired zero register are dropped here.
    assign w_wa_ok    = wa_en_i    && !(ZERO_EN && (wa_addr_i    == '0));
    assign w_wb_ok    = wb_en_i    && !(ZERO_EN && (wb_addr_i    == '0));
    assign w_claim_ok = claim_en_i && !(ZERO_EN && (claim_addr_i == '0));

    // Claim is applied after the B-write clear so it wins on the same address.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wb_ok) begin
            w_busy_next[wb_addr_i] = 1'b0;
        end
        if (w_claim_ok) begin
            w_busy_next[claim_addr_i] = 1'b1;
        end
    end

    // Port A is written last so it owns the register on an address collision.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_regs[ADDR_W'(i)] <= '0;
            end
            r_busy     <= '0;
            r_busy_any <= 1'b0;
        end else begin
            if (w_wb_ok) begin
                r_regs[wb_addr_i] <= wb_data_i;
            end
            if (w_wa_ok) begin
                r_regs[wa_addr_i] <= wa_data_i;
            end
            r_busy     <= w_busy_next;
            r_busy_any <= |w_busy_next;
        end
    end

    assign dbg_data_o = r_regs[ADDR_W'(DEBUG_REG)];
    assign busy_any_o = r_busy_any;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = rd_addr_i[k*ADDR_W +: ADDR_W];

        // Stored value, optionally overridden by same-cycle writes (A over B).
        always_comb begin
            w_data = r_regs[w_addr];
            w_busy = r_busy[w_addr];
            if (BYPASS != 0) begin
                if (w_wb_ok && (wb_addr_i == w_addr)) begin
                    w_data = wb_data_i;
                    if (!(w_claim_ok && (claim_addr_i == w_addr))) begin
                        w_busy = 1'b0;
                    end
                end
                if (w_wa_ok && (wa_addr_i == w_addr)) begin
                    w_data = wa_data_i;
                end
            end
            if (ZERO_EN && (w_addr == '0)) begin
                w_data = '0;
                w_busy = 1'b0;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = w_data;
        assign rd_busy_o[k]                  = w_busy;
    end

endmodule
